// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2,
    DOOR    = 2'd3
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // OR of the request bits strictly above (upper=1) or strictly below (upper=0) idx.
  // Vectors are zero-extended to 32 bits so one helper covers every floor count.
  function automatic logic masked_or(input logic [31:0] vec, input logic [4:0] idx,
                                     input logic upper);
    logic [31:0] low_mask;
    logic [31:0] self_bit;
    self_bit = 32'd1 << idx;
    low_mask = self_bit - 32'd1;
    if (upper) begin
      return |(vec & ~low_mask & ~self_bit);
    end
    return |(vec & low_mask);
  endfunction

endpackage

// File: rtl/elevator_req_latch.sv
// Sticky pending-request register plus the above/below reductions used by dispatch.
module elevator_req_latch
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  localparam int FLOOR_W = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  clr_en,
  input  logic [FLOOR_W-1:0]    clr_floor,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  above,
  output logic                  below
);

  logic [NUM_FLOORS-1:0] pending_q;
  logic [NUM_FLOORS-1:0] pending_d;

  // The floor the car is (or is about to be) standing at with the door open
  // never latches; every other bit keeps set-beats-clear behaviour.
  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_bit
    assign pending_d[gi] = (pending_q[gi] | req[gi]) &
                           ~(clr_en && (clr_floor == FLOOR_W'(gi)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
  assign above   = masked_or(32'(pending_q), 5'(cur_floor), 1'b1);
  assign below   = masked_or(32'(pending_q), 5'(cur_floor), 1'b0);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN (collective) elevator controller: dispatch FSM and door dwell timer.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 8,
  parameter int DWELL_CYCLES = 100,
  localparam int FLOOR_W = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] floor_sensors,
  input  logic [NUM_FLOORS-1:0] request_buttons,
  input  logic [NUM_FLOORS-1:0] elevator_buttons,
  input  logic                  door_hold,
  output logic                  dir,
  output logic                  move,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  arrive
);

  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  state_t               state_q, state_d;
  logic                 dir_q, dir_d;
  logic                 move_q, move_d;
  logic                 door_open_q, door_open_d;
  logic                 arrive_q, arrive_d;
  logic [FLOOR_W-1:0]   floor_q, floor_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;

  logic [NUM_FLOORS-1:0] req_any;
  logic [NUM_FLOORS-1:0] pending_vec;
  logic                  above, below;
  logic                  door_next;
  logic [FLOOR_W-1:0]    floor_up, floor_dn;

  assign req_any   = request_buttons | elevator_buttons;
  assign floor_up  = floor_q + 1'b1;
  assign floor_dn  = floor_q - 1'b1;
  assign door_next = (state_d == DOOR);

  elevator_req_latch #(
    .NUM_FLOORS(NUM_FLOORS)
  ) u_req_latch (
    .clk      (clk),
    .reset    (reset),
    .req      (req_any),
    .clr_en   (door_next),
    .clr_floor(floor_d),
    .cur_floor(floor_q),
    .pending  (pending_vec),
    .above    (above),
    .below    (below)
  );

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    move_d      = move_q;
    door_open_d = door_open_q;
    floor_d     = floor_q;
    dwell_d     = dwell_q;
    arrive_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending_vec[floor_q]) begin
          state_d     = DOOR;
          door_open_d = 1'b1;
          arrive_d    = 1'b1;
          dwell_d     = '0;
        end else if (above && (dir_q == DIR_UP || !below)) begin
          state_d = MOVE_UP;
          dir_d   = DIR_UP;
          move_d  = 1'b1;
        end else if (below) begin
          state_d = MOVE_DN;
          dir_d   = DIR_DN;
          move_d  = 1'b1;
        end
      end
      MOVE_UP: begin
        if (floor_q != TOP_FLOOR && floor_sensors[floor_up]) begin
          floor_d = floor_up;
          if (pending_vec[floor_up]) begin
            state_d     = DOOR;
            move_d      = 1'b0;
            door_open_d = 1'b1;
            arrive_d    = 1'b1;
            dwell_d     = '0;
          end
        end
      end
      MOVE_DN: begin
        if (floor_q != '0 && floor_sensors[floor_dn]) begin
          floor_d = floor_dn;
          if (pending_vec[floor_dn]) begin
            state_d     = DOOR;
            move_d      = 1'b0;
            door_open_d = 1'b1;
            arrive_d    = 1'b1;
            dwell_d     = '0;
          end
        end
      end
      DOOR: begin
        // A fresh call at this floor behaves like a hold: keep the door open.
        if (door_hold || req_any[floor_q]) begin
          dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
          state_d     = IDLE;
          door_open_d = 1'b0;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        move_d      = 1'b0;
        door_open_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_q       <= DIR_DN;
      move_q      <= 1'b0;
      door_open_q <= 1'b0;
      arrive_q    <= 1'b0;
      floor_q     <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      move_q      <= move_d;
      door_open_q <= door_open_d;
      arrive_q    <= arrive_d;
      floor_q     <= floor_d;
      dwell_q     <= dwell_d;
    end
  end

  assign dir           = dir_q;
  assign move          = move_q;
  assign door_open     = door_open_q;
  assign arrive        = arrive_q;
  assign current_floor = floor_q;
  assign pending       = pending_vec;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: vector table, directed SCAN/reset/boundary sequences, random run vs model.
module tb_elevator_scan_ctrl;

  localparam int N  = 8;
  localparam int D  = 4;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  floor_sensors = '0;
  logic [N-1:0]  request_buttons = '0;
  logic [N-1:0]  elevator_buttons = '0;
  logic          door_hold = 1'b0;
  logic          dir, move, door_open, arrive;
  logic [FW-1:0] current_floor;
  logic [N-1:0]  pending;

  int checks = 0;
  int errors = 0;

  elevator_scan_ctrl #(.NUM_FLOORS(N), .DWELL_CYCLES(D)) dut (
    .clk             (clk),
    .reset           (reset),
    .floor_sensors   (floor_sensors),
    .request_buttons (request_buttons),
    .elevator_buttons(elevator_buttons),
    .door_hold       (door_hold),
    .dir             (dir),
    .move            (move),
    .door_open       (door_open),
    .current_floor   (current_floor),
    .pending         (pending),
    .arrive          (arrive)
  );

  always #5 clk = ~clk;

  // Reference model: car position as an integer, requests as a bit set.
  typedef enum {M_IDLE, M_UP, M_DN, M_DOOR} mst_t;
  mst_t     m_state;
  int       m_floor, m_dwell;
  bit       m_dir, m_move, m_door, m_arr;
  bit [N-1:0] m_pend;

  task automatic model_reset();
    m_state = M_IDLE; m_floor = 0; m_dwell = 0;
    m_dir = 0; m_move = 0; m_door = 0; m_arr = 0; m_pend = '0;
  endtask

  task automatic model_step(input logic [N-1:0] rb, input logic [N-1:0] eb,
                            input logic [N-1:0] sens, input logic hold);
    logic [N-1:0] req;
    mst_t ns;
    int nf, ndw;
    bit ndir, nmove, ndoor, narr, ab, be;
    req = rb | eb;
    ns = m_state; nf = m_floor; ndw = m_dwell;
    ndir = m_dir; nmove = m_move; ndoor = m_door; narr = 0;
    ab = 0; be = 0;
    for (int j = 0; j < N; j++) begin
      if (m_pend[j] && j > m_floor) ab = 1;
      if (m_pend[j] && j < m_floor) be = 1;
    end
    case (m_state)
      M_IDLE: begin
        if (m_pend[m_floor]) begin
          ns = M_DOOR; ndw = 0; narr = 1; ndoor = 1;
        end else if (ab && (m_dir || !be)) begin
          ns = M_UP; ndir = 1; nmove = 1;
        end else if (be) begin
          ns = M_DN; ndir = 0; nmove = 1;
        end
      end
      M_UP, M_DN: begin
        int tgt;
        tgt = (m_state == M_UP) ? m_floor + 1 : m_floor - 1;
        if (tgt >= 0 && tgt < N && sens[tgt]) begin
          nf = tgt;
          if (m_pend[tgt]) begin
            ns = M_DOOR; nmove = 0; ndoor = 1; narr = 1; ndw = 0;
          end
        end
      end
      M_DOOR: begin
        if (hold || req[m_floor]) ndw = 0;
        else if (m_dwell == D - 1) begin ns = M_IDLE; ndoor = 0; end
        else ndw = m_dwell + 1;
      end
      default: ;
    endcase
    for (int j = 0; j < N; j++) begin
      m_pend[j] = m_pend[j] | req[j];
      if (ns == M_DOOR && j == nf) m_pend[j] = 0;
    end
    m_state = ns; m_floor = nf; m_dwell = ndw;
    m_dir = ndir; m_move = nmove; m_door = ndoor; m_arr = narr;
  endtask

  task automatic check_vs_model(input string tag);
    logic [FW-1:0] mf;
    mf = m_floor[FW-1:0];
    checks++;
    if ({dir, move, door_open, arrive, current_floor, pending} !==
        {m_dir, m_move, m_door, m_arr, mf, m_pend}) begin
      errors++;
      $display("FAIL %s t=%0t got dir=%b move=%b door=%b arr=%b floor=%0d pend=%h want dir=%b move=%b door=%b arr=%b floor=%0d pend=%h",
               tag, $time, dir, move, door_open, arrive, current_floor, pending,
               m_dir, m_move, m_door, m_arr, mf, m_pend);
    end
  endtask

  task automatic cycle(input logic [N-1:0] rb, input logic [N-1:0] eb,
                       input logic [N-1:0] sens, input logic hold);
    request_buttons = rb; elevator_buttons = eb; floor_sensors = sens; door_hold = hold;
    @(posedge clk);
    model_step(rb, eb, sens, hold);
    #1;
    check_vs_model("model");
    $display("cyc t=%0t rb=%h eb=%h s=%h h=%b -> dir=%b move=%b door=%b arr=%b floor=%0d pend=%h",
             $time, rb, eb, sens, hold, dir, move, door_open, arrive, current_floor, pending);
  endtask

  task automatic do_reset();
    request_buttons = '0; elevator_buttons = '0; floor_sensors = '0; door_hold = 0;
    reset = 1;
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    check_vs_model("reset");
  endtask

  // Drives the sensor one floor ahead of a moving car until it stops.
  task automatic run_to_stop(input int exp_floor, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      logic [N-1:0] s;
      s = '0;
      if (move && dir && current_floor < FW'(N - 1)) s[current_floor + 1] = 1'b1;
      else if (move && !dir && current_floor > 0) s[current_floor - 1] = 1'b1;
      cycle('0, '0, s, 1'b0);
      hit = arrive;
    end
    checks++;
    if (!hit || current_floor != FW'(exp_floor)) begin
      errors++;
      $display("FAIL stop got arrive=%b floor=%0d want arrive=1 floor=%0d", hit, current_floor, exp_floor);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && door_open; i++) cycle('0, '0, '0, 1'b0);
    checks++;
    if (door_open !== 1'b0) begin
      errors++;
      $display("FAIL door_close got door_open=%b want 0", door_open);
    end
  endtask

  typedef struct {
    logic [N-1:0] rb, eb, sens;
    logic         hold;
    logic         e_move, e_door, e_dir, e_arr;
    logic [FW-1:0] e_floor;
    logic [N-1:0] e_pend;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [N-1:0] rb, input logic [N-1:0] eb, input logic [N-1:0] sens,
                         input logic hold, input logic mv, input logic dr, input logic di,
                         input logic ar, input int fl, input logic [N-1:0] pd);
    vec_t v;
    v.rb = rb; v.eb = eb; v.sens = sens; v.hold = hold;
    v.e_move = mv; v.e_door = dr; v.e_dir = di; v.e_arr = ar;
    v.e_floor = FW'(fl); v.e_pend = pd;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Single car call to floor 5, then same-floor request, then door hold.
    add_vec(0, 8'h20, 0, 0, 0, 0, 0, 0, 0, 8'h20);
    add_vec(0, 0, 0, 0, 1, 0, 1, 0, 0, 8'h20);
    add_vec(0, 0, 8'h02, 0, 1, 0, 1, 0, 1, 8'h20);
    add_vec(0, 0, 8'h04, 0, 1, 0, 1, 0, 2, 8'h20);
    add_vec(0, 0, 8'h00, 0, 1, 0, 1, 0, 2, 8'h20);
    add_vec(0, 0, 8'h08, 0, 1, 0, 1, 0, 3, 8'h20);
    add_vec(0, 0, 8'h10, 0, 1, 0, 1, 0, 4, 8'h20);
    add_vec(0, 0, 8'h20, 0, 0, 1, 1, 1, 5, 8'h00);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 0, 0, 0, 1, 1, 0, 5, 8'h00);
    add_vec(0, 0, 0, 0, 0, 0, 1, 0, 5, 8'h00);
    add_vec(0, 0, 8'hFF, 0, 0, 0, 1, 0, 5, 8'h00);
    add_vec(8'h20, 0, 0, 0, 0, 0, 1, 0, 5, 8'h20);
    add_vec(0, 0, 0, 0, 0, 1, 1, 1, 5, 8'h00);
    add_vec(8'h20, 0, 0, 0, 0, 1, 1, 0, 5, 8'h00);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 0, 0, 0, 1, 1, 0, 5, 8'h00);
    add_vec(0, 0, 0, 0, 0, 0, 1, 0, 5, 8'h00);
    add_vec(0, 8'h20, 0, 0, 0, 0, 1, 0, 5, 8'h20);
    add_vec(0, 0, 0, 0, 0, 1, 1, 1, 5, 8'h00);
    for (int i = 0; i < 10; i++) add_vec(0, 0, 0, 1, 0, 1, 1, 0, 5, 8'h00);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 0, 0, 0, 1, 1, 0, 5, 8'h00);
    add_vec(0, 0, 0, 0, 0, 0, 1, 0, 5, 8'h00);

    do_reset();
    checks++;
    if ({dir, move, door_open, arrive, current_floor, pending} !== '0) begin
      errors++;
      $display("FAIL reset_state got dir=%b move=%b door=%b arr=%b floor=%0d pend=%h want all 0",
               dir, move, door_open, arrive, current_floor, pending);
    end

    foreach (vecs[i]) begin
      cycle(vecs[i].rb, vecs[i].eb, vecs[i].sens, vecs[i].hold);
      checks++;
      if ({move, door_open, dir, arrive, current_floor, pending} !==
          {vecs[i].e_move, vecs[i].e_door, vecs[i].e_dir, vecs[i].e_arr, vecs[i].e_floor, vecs[i].e_pend}) begin
        errors++;
        $display("FAIL vec%0d got move=%b door=%b dir=%b arr=%b floor=%0d pend=%h want move=%b door=%b dir=%b arr=%b floor=%0d pend=%h",
                 i, move, door_open, dir, arrive, current_floor, pending, vecs[i].e_move, vecs[i].e_door,
                 vecs[i].e_dir, vecs[i].e_arr, vecs[i].e_floor, vecs[i].e_pend);
      end
    end

    // SCAN ordering: up to 4, then 2 and 6 pending plus a hall call at 5.
    do_reset();
    cycle('0, 8'h10, '0, 1'b0);
    run_to_stop(4, 20);
    cycle(8'h20, 8'h44, '0, 1'b0);
    wait_idle(20);
    run_to_stop(5, 20);
    wait_idle(20);
    run_to_stop(6, 20);
    wait_idle(20);
    run_to_stop(2, 20);
    checks++;
    if (dir !== 1'b0) begin
      errors++;
      $display("FAIL scan_reverse got dir=%b want 0", dir);
    end
    wait_idle(20);

    // Asynchronous reset in the middle of a dwell.
    cycle('0, 8'h08, '0, 1'b0);
    run_to_stop(3, 20);
    cycle('0, '0, '0, 1'b0);
    #3 reset = 1;
    #1;
    checks++;
    if ({dir, move, door_open, arrive, current_floor, pending} !== '0) begin
      errors++;
      $display("FAIL async_reset got dir=%b move=%b door=%b arr=%b floor=%0d pend=%h want all 0",
               dir, move, door_open, arrive, current_floor, pending);
    end
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    check_vs_model("post_reset");

    // Top floor: a request at 7 while parked there opens the door only.
    cycle('0, 8'h80, '0, 1'b0);
    run_to_stop(7, 30);
    wait_idle(20);
    cycle(8'h80, '0, '0, 1'b0);
    cycle('0, '0, '0, 1'b0);
    checks++;
    if (!(door_open === 1'b1 && move === 1'b0 && arrive === 1'b1 && current_floor === 3'd7)) begin
      errors++;
      $display("FAIL top_door got door=%b move=%b arr=%b floor=%0d want door=1 move=0 arr=1 floor=7",
               door_open, move, arrive, current_floor);
    end
    wait_idle(20);

    // Floor 0, nothing pending, noisy sensors: the car must not move.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle('0, '0, N'($urandom), 1'b0);
      checks++;
      if (move !== 1'b0 || current_floor !== 3'd0) begin
        errors++;
        $display("FAIL spurious_sensor got move=%b floor=%0d want move=0 floor=0", move, current_floor);
      end
    end

    // Random traffic against the reference model.
    begin
      logic hold_r;
      hold_r = 0;
      for (int i = 0; i < 3000; i++) begin
        logic [N-1:0] rb, eb, s;
        rb = '0; eb = '0;
        if ($urandom_range(0, 9) == 0) rb[$urandom_range(0, N - 1)] = 1'b1;
        if ($urandom_range(0, 9) == 0) eb[$urandom_range(0, N - 1)] = 1'b1;
        if ($urandom_range(0, 15) == 0) hold_r = ~hold_r;
        s = N'($urandom) & N'($urandom);
        cycle(rb, eb, s, hold_r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
